// File: rtl/alarm_ctrl.sv
// Alarm comparator and ring/snooze/stop state machine timed by the 1 Hz tick.
// Optional ALARM_BEEP_PATTERN_EN: 1 s on / 1 s off buzzer pattern while ringing.
module alarm_ctrl #(
  parameter int SNOOZE_SEC = 540,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sec_tick,
  input  logic       alarm_en,
  input  logic       editing,
  input  logic [3:0] time_hT,
  input  logic [3:0] time_hU,
  input  logic [3:0] time_mT,
  input  logic [3:0] time_mU,
  input  logic [3:0] alm_hT,
  input  logic [3:0] alm_hU,
  input  logic [3:0] alm_mT,
  input  logic [3:0] alm_mU,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzz,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_cnt,
  output logic [1:0] fsm_state
);

  localparam int MAX_SEC = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
  localparam int CW      = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] sec_cnt, sec_cnt_nx;
  logic [3:0]    snooze_cnt_nx;
  logic          match, match_q, trigger;

  assign match = (time_hT == alm_hT) && (time_hU == alm_hU) &&
                 (time_mT == alm_mT) && (time_mU == alm_mU) && !editing;
  // Rising edge of match: one trigger per matching minute.
  assign trigger = match && !match_q;

  assign fsm_state = state;

  always_comb begin
    state_nx      = state;
    sec_cnt_nx    = sec_cnt;
    snooze_cnt_nx = snooze_cnt;
    if (!alarm_en) begin
      state_nx      = DISARMED;
      sec_cnt_nx    = '0;
      snooze_cnt_nx = '0;
    end else begin
      case (state)
        DISARMED: state_nx = ARMED;
        ARMED: begin
          if (trigger) begin
            state_nx      = RINGING;
            sec_cnt_nx    = '0;
            snooze_cnt_nx = '0;
          end
        end
        RINGING: begin
          // A button press always consumes a coincident tick.
          if (stop_btn) begin
            state_nx      = ARMED;
            sec_cnt_nx    = '0;
            snooze_cnt_nx = '0;
          end else if (snooze_btn) begin
            if (snooze_cnt < 4'(MAX_SNOOZE)) begin
              state_nx      = SNOOZE;
              sec_cnt_nx    = '0;
              snooze_cnt_nx = snooze_cnt + 4'd1;
            end
          end else if (sec_tick) begin
            if (sec_cnt == CW'(RING_SEC - 1)) begin
              state_nx      = ARMED;
              sec_cnt_nx    = '0;
              snooze_cnt_nx = '0;
            end else begin
              sec_cnt_nx = sec_cnt + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_nx      = ARMED;
            sec_cnt_nx    = '0;
            snooze_cnt_nx = '0;
          end else if (!snooze_btn && sec_tick) begin
            if (sec_cnt == CW'(SNOOZE_SEC - 1)) begin
              state_nx   = RINGING;
              sec_cnt_nx = '0;
            end else begin
              sec_cnt_nx = sec_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx      = DISARMED;
          sec_cnt_nx    = '0;
          snooze_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= DISARMED;
      sec_cnt    <= '0;
      snooze_cnt <= '0;
      match_q    <= 1'b1;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state      <= state_nx;
      sec_cnt    <= sec_cnt_nx;
      snooze_cnt <= snooze_cnt_nx;
      match_q    <= match;
      ringing    <= (state_nx == RINGING);
      snoozing   <= (state_nx == SNOOZE);
    end
  end

`ifdef ALARM_BEEP_PATTERN_EN
  logic beep_phase;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beep_phase <= 1'b0;
    end else if (state_nx == RINGING && state != RINGING) begin
      beep_phase <= 1'b1;
    end else if (state == RINGING && sec_tick) begin
      beep_phase <= !beep_phase;
    end
  end

  assign buzz = ringing && beep_phase;
`else
  assign buzz = ringing;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short timers (SNOOZE_SEC=5, RING_SEC=8, MAX_SNOOZE=2).
module tb_alarm_ctrl;

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_RINGING  = 2'd2;
  localparam logic [1:0] S_SNOOZE   = 2'd3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sec_tick = 1'b0;
  logic        alarm_en = 1'b0;
  logic        editing = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic [15:0] tm = 16'h0000;
  logic [15:0] alm = 16'h0730;
  logic        buzz, ringing, snoozing;
  logic [3:0]  snooze_cnt;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alarm_ctrl #(.SNOOZE_SEC(5), .RING_SEC(8), .MAX_SNOOZE(2)) dut (
    .clk(clk), .resetn(resetn), .sec_tick(sec_tick), .alarm_en(alarm_en),
    .editing(editing),
    .time_hT(tm[15:12]), .time_hU(tm[11:8]), .time_mT(tm[7:4]), .time_mU(tm[3:0]),
    .alm_hT(alm[15:12]), .alm_hU(alm[11:8]), .alm_mT(alm[7:4]), .alm_mU(alm[3:0]),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .buzz(buzz), .ringing(ringing), .snoozing(snoozing),
    .snooze_cnt(snooze_cnt), .fsm_state(fsm_state)
  );

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    cyc();
  endtask

  task automatic press_stop();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
  endtask

  // Approach the alarm minute from 07:29 so the match has a rising edge.
  task automatic start_ring();
    tm = 16'h0729;
    cyc(2);
    tm = 16'h0730;
    cyc();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    alarm_en = 1'b1;
    tm = 16'h0730;
    cyc(2);
    total++; if (fsm_state !== S_DISARMED) begin bad++; $display("FAIL rst_state got=%0d want=%0d", fsm_state, S_DISARMED); end
    total++; if ({buzz, ringing, snoozing} !== 3'b000) begin bad++; $display("FAIL rst_outs got=%b want=000", {buzz, ringing, snoozing}); end
    total++; if (snooze_cnt !== 4'd0) begin bad++; $display("FAIL rst_snz got=%0d want=0", snooze_cnt); end
    resetn = 1'b1;
    cyc(4);
    // Time already equals alarm when coming out of reset: no edge, no ring.
    total++; if (fsm_state !== S_ARMED) begin bad++; $display("FAIL rst_armed got=%0d want=%0d", fsm_state, S_ARMED); end
    total++; if (ringing !== 1'b0) begin bad++; $display("FAIL rst_no_ring got=%b want=0", ringing); end
  endtask

  task automatic test_trigger();
    int ring_seen;
    start_ring();
    total++; if (ringing !== 1'b1 || buzz !== 1'b1) begin bad++; $display("FAIL trig_ring got=%b%b want=11", ringing, buzz); end
    total++; if (fsm_state !== S_RINGING) begin bad++; $display("FAIL trig_state got=%0d want=%0d", fsm_state, S_RINGING); end
    press_stop();
    total++; if (fsm_state !== S_ARMED || ringing !== 1'b0) begin bad++; $display("FAIL trig_stop got=%0d/%b want=%0d/0", fsm_state, ringing, S_ARMED); end
    ring_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (ringing) ring_seen++;
    end
    total++; if (ring_seen !== 0) begin bad++; $display("FAIL trig_hold ring_cycles got=%0d want=0", ring_seen); end
  endtask

  task automatic test_ring_timeout();
    start_ring();
    for (int i = 0; i < 7; i++) tick();
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL tmo_7 got=%b want=1", ringing); end
    tick();
    total++; if (ringing !== 1'b0 || fsm_state !== S_ARMED) begin bad++; $display("FAIL tmo_8 got=%b/%0d want=0/%0d", ringing, fsm_state, S_ARMED); end
  endtask

  task automatic test_snooze();
    start_ring();
    press_snooze();
    total++; if (snoozing !== 1'b1 || snooze_cnt !== 4'd1 || buzz !== 1'b0) begin bad++; $display("FAIL snz1 got=%b/%0d/%b want=1/1/0", snoozing, snooze_cnt, buzz); end
    for (int i = 0; i < 4; i++) tick();
    total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL snz1_4ticks got=%b want=1", snoozing); end
    tick();
    total++; if (ringing !== 1'b1 || snooze_cnt !== 4'd1) begin bad++; $display("FAIL snz1_wake got=%b/%0d want=1/1", ringing, snooze_cnt); end
    press_snooze();
    total++; if (snoozing !== 1'b1 || snooze_cnt !== 4'd2) begin bad++; $display("FAIL snz2 got=%b/%0d want=1/2", snoozing, snooze_cnt); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL snz2_wake got=%b want=1", ringing); end
    press_snooze();
    total++; if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_cnt !== 4'd2) begin bad++; $display("FAIL snz3_ignored got=%b/%b/%0d want=1/0/2", ringing, snoozing, snooze_cnt); end
    press_stop();
    total++; if (fsm_state !== S_ARMED || snooze_cnt !== 4'd0) begin bad++; $display("FAIL snz_stop got=%0d/%0d want=%0d/0", fsm_state, snooze_cnt, S_ARMED); end
  endtask

  task automatic test_stop_and_snooze();
    start_ring();
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    total++; if (fsm_state !== S_ARMED || snooze_cnt !== 4'd0 || snoozing !== 1'b0) begin bad++; $display("FAIL both_btn got=%0d/%0d/%b want=%0d/0/0", fsm_state, snooze_cnt, snoozing, S_ARMED); end
  endtask

  task automatic test_button_beats_tick();
    start_ring();
    for (int i = 0; i < 7; i++) tick();
    // Tick at the ring terminal count coincides with snooze: snooze wins.
    sec_tick = 1'b1;
    snooze_btn = 1'b1;
    cyc();
    sec_tick = 1'b0;
    snooze_btn = 1'b0;
    total++; if (snoozing !== 1'b1 || snooze_cnt !== 4'd1) begin bad++; $display("FAIL btn_tick_ring got=%b/%0d want=1/1", snoozing, snooze_cnt); end
    for (int i = 0; i < 4; i++) tick();
    sec_tick = 1'b1;
    snooze_btn = 1'b1;
    cyc();
    sec_tick = 1'b0;
    snooze_btn = 1'b0;
    total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL btn_tick_snz got=%b want=1", snoozing); end
    tick();
    total++; if (ringing !== 1'b1) begin bad++; $display("FAIL btn_tick_wake got=%b want=1", ringing); end
    press_stop();
  endtask

  task automatic test_editing();
    tm = 16'h0729;
    cyc(2);
    editing = 1'b1;
    tm = 16'h0730;
    cyc(5);
    total++; if (ringing !== 1'b0 || fsm_state !== S_ARMED) begin bad++; $display("FAIL edit_no_ring got=%b/%0d want=0/%0d", ringing, fsm_state, S_ARMED); end
    tm = 16'h0731;
    cyc();
    editing = 1'b0;
    cyc(3);
  endtask

  task automatic test_enable_during_match();
    alarm_en = 1'b0;
    cyc();
    total++; if (fsm_state !== S_DISARMED) begin bad++; $display("FAIL en_disarm got=%0d want=%0d", fsm_state, S_DISARMED); end
    tm = 16'h0729;
    cyc(2);
    tm = 16'h0730;
    cyc(3);
    alarm_en = 1'b1;
    cyc(5);
    total++; if (fsm_state !== S_ARMED || ringing !== 1'b0) begin bad++; $display("FAIL en_in_match got=%0d/%b want=%0d/0", fsm_state, ringing, S_ARMED); end
  endtask

  task automatic test_disable_in_snooze();
    start_ring();
    press_snooze();
    alarm_en = 1'b0;
    cyc();
    total++; if (fsm_state !== S_DISARMED || snooze_cnt !== 4'd0 || snoozing !== 1'b0) begin bad++; $display("FAIL dis_snz got=%0d/%0d/%b want=%0d/0/0", fsm_state, snooze_cnt, snoozing, S_DISARMED); end
    alarm_en = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset_mid_ring();
    start_ring();
    tick();
    resetn = 1'b0;
    cyc();
    total++; if ({buzz, ringing, snoozing} !== 3'b000 || snooze_cnt !== 4'd0 || fsm_state !== S_DISARMED) begin bad++; $display("FAIL rst_mid got=%b/%0d/%0d want=000/0/%0d", {buzz, ringing, snoozing}, snooze_cnt, fsm_state, S_DISARMED); end
    resetn = 1'b1;
    cyc(2);
  endtask

`ifdef ALARM_BEEP_PATTERN_EN
  task automatic test_beep();
    start_ring();
    total++; if (buzz !== 1'b1) begin bad++; $display("FAIL beep_entry got=%b want=1", buzz); end
    tick();
    total++; if (buzz !== 1'b0) begin bad++; $display("FAIL beep_t1 got=%b want=0", buzz); end
    tick();
    total++; if (buzz !== 1'b1) begin bad++; $display("FAIL beep_t2 got=%b want=1", buzz); end
    press_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_trigger();
    test_ring_timeout();
    test_snooze();
    test_stop_and_snooze();
    test_button_beats_tick();
    test_editing();
    test_enable_during_match();
    test_disable_in_snooze();
    test_reset_mid_ring();
`ifdef ALARM_BEEP_PATTERN_EN
    test_beep();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
